mem_responder_multi: RTL and testbench

Memory-side responder for the multicycle processor's shared instruction/data memory port. It accepts the controller's MemRead/MemWrite strobes plus the datapath's address, write data and access size, and services them from an internal word array after a configurable number of wait states. Read data is held stable for the datapath's IR/MDR capture, and a one-cycle ready pulse marks completion. It sits between the IouD address mux and the IR/MDR registers.

---
 rtl/mem_responder_multi_pkg.sv | 37 +++
 rtl/mem_responder_multi_byte_lane.sv | 56 +++++
 rtl/mem_responder_multi.sv | 205 ++++++++++++++++++++
 tb/tb_mem_responder_multi.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_multi_pkg.sv
// mem_responder_multi_pkg
// Shared constants and types for the multicycle memory responder.
//   FUNCT3_*            load/store size encodings as driven by the datapath
//   RSP_IDLE/WAIT/RESP  responder FSM encodings (kept apart from the ST_* controller names)
//   accessSize()        maps funct3 onto byte/half/word; unsupported codes fall back to word
package mem_responder_multi_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } rspState_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } accSize_t;

    function automatic accSize_t accessSize(input logic [2:0] funct3);
        case (funct3)
            FUNCT3_LB, FUNCT3_LBU: accessSize = SIZE_BYTE;
            FUNCT3_LH, FUNCT3_LHU: accessSize = SIZE_HALF;
            default:               accessSize = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_multi_byte_lane.sv
// mem_byte_lane
// Combinational byte-lane steering for the memory responder.
//   iFunct3      access size/sign
//   iByteOff     address bits [1:0]
//   iWriteData   store data, lane 0 aligned
//   iReadWord    word currently held in the array at the target index
//   oLaneMask    byte lanes to update on a store
//   oStoreData   store data replicated so each enabled lane sees its byte
//   oLoadData    extracted and sign/zero-extended load result
//   oMisaligned  half on an odd address or word on a non-zero offset
module mem_byte_lane
    import mem_responder_multi_pkg::*;
(
    input  logic [2:0]  iFunct3,
    input  logic [1:0]  iByteOff,
    input  logic [31:0] iWriteData,
    input  logic [31:0] iReadWord,
    output logic [3:0]  oLaneMask,
    output logic [31:0] oStoreData,
    output logic [31:0] oLoadData,
    output logic        oMisaligned
);

    accSize_t    size;
    logic [31:0] shifted;
    logic        isUnsigned;

    always_comb begin
        size        = accessSize(iFunct3);
        isUnsigned  = iFunct3[2];
        shifted     = iReadWord >> {iByteOff, 3'b000};
        oLaneMask   = 4'b1111;
        oStoreData  = iWriteData;
        oLoadData   = iReadWord;
        oMisaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                oLaneMask  = 4'b0001 << iByteOff;
                oStoreData = {4{iWriteData[7:0]}};
                oLoadData  = isUnsigned ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                oMisaligned = iByteOff[0];
                oLaneMask   = iByteOff[1] ? 4'b1100 : 4'b0011;
                oStoreData  = {2{iWriteData[15:0]}};
                oLoadData   = isUnsigned ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                oMisaligned = |iByteOff;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder_multi.sv
// mem_responder_multi
// Memory-side responder for the multicycle processor's shared I/D port.
// Services one access per strobe after WAIT_CYCLES wait states, then pulses
// oReady for one cycle. Strobes held into WAIT/RESP are ignored.
//
// Parameters: ADDR_W (word-address bits), WAIT_CYCLES (0..15)
// Ports:
//   iCLK, iRST_N           clock, async active-low reset
//   iMemRead, iMemWrite    controller strobes (both high = write + fault)
//   iAddress               byte address; bits above ADDR_W+1 alias
//   iWriteData, iFunct3    store data and access size/sign
//   oReadData              registered load data, held until the next read
//   oReady, oFault         one-cycle completion pulse and its fault flag
//   oBusy                  FSM not in IDLE
//
// Build option MEM_BYTE_LANES_EN: enables sub-word access and misalignment
// detection. Without it every access is a full word and only simultaneous
// strobes fault.
//
// State table
//   state    | meaning
//   RSP_IDLE | waiting for a strobe; fields latched on acceptance
//   RSP_WAIT | counting down wait states, access on the count==1 edge
//   RSP_RESP | oReady/oFault valid for this single cycle
module mem_responder_multi
    import mem_responder_multi_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    input  logic [2:0]  iFunct3,
    output logic [31:0] oReadData,
    output logic        oReady,
    output logic        oBusy,
    output logic        oFault
);

    localparam int         WORDS     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    rspState_t         state, nextState;
    logic [3:0]        waitCnt, nextWaitCnt;
    logic              latchEn, doAccess;

    logic [ADDR_W+1:0] addrQ;
    logic [31:0]       wdataQ;
    logic [2:0]        funct3Q;
    logic              writeQ, bothQ;

    logic              liveSel;
    logic [ADDR_W+1:0] accAddr;
    logic [31:0]       accWData;
    logic [2:0]        accFunct3;
    logic              accWrite, accBoth;

    logic [2:0]        laneFunct3;
    logic [1:0]        laneOff;
    logic [3:0]        laneMask;
    logic [31:0]       storeData, loadData, memWord;
    logic              misaligned, memWe;
    logic [ADDR_W-1:0] memIdx;

    logic [31:0]       mem [WORDS];

    logic              unusedAddrBits;
    assign unusedAddrBits = ^iAddress[31:ADDR_W+2];

    // ---------------- FSM ----------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= RSP_IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        latchEn     = 1'b0;
        doAccess    = 1'b0;
        oBusy       = (state != RSP_IDLE);
        case (state)
            RSP_IDLE: begin
                if (iMemRead | iMemWrite) begin
                    latchEn = 1'b1;
                    if (NO_WAIT) begin
                        doAccess  = 1'b1;
                        nextState = RSP_RESP;
                    end else begin
                        nextWaitCnt = WAIT_LOAD;
                        nextState   = RSP_WAIT;
                    end
                end
            end
            RSP_WAIT: begin
                if (waitCnt <= 4'd1) begin
                    doAccess    = 1'b1;
                    nextWaitCnt = 4'd0;
                    nextState   = RSP_RESP;
                end else begin
                    nextWaitCnt = waitCnt - 4'd1;
                end
            end
            RSP_RESP: begin
                nextState = RSP_IDLE;
            end
            default: begin
                nextState   = RSP_IDLE;
                nextWaitCnt = 4'd0;
            end
        endcase
    end

    // Zero-wait accesses happen on the acceptance edge, so they must see the
    // live inputs; delayed accesses only ever see the latched copy.
    assign liveSel   = (state == RSP_IDLE);
    assign accAddr   = liveSel ? iAddress[ADDR_W+1:0]   : addrQ;
    assign accWData  = liveSel ? iWriteData             : wdataQ;
    assign accFunct3 = liveSel ? iFunct3                : funct3Q;
    assign accWrite  = liveSel ? iMemWrite              : writeQ;
    assign accBoth   = liveSel ? (iMemRead & iMemWrite) : bothQ;

`ifdef MEM_BYTE_LANES_EN
    assign laneFunct3 = accFunct3;
    assign laneOff    = accAddr[1:0];
`else
    assign laneFunct3 = FUNCT3_LW;
    assign laneOff    = 2'b00;
    logic unusedLaneBits;
    assign unusedLaneBits = ^{accFunct3, accAddr[1:0]};
`endif

    assign memIdx  = accAddr[ADDR_W+1:2];
    assign memWord = mem[memIdx];

    mem_byte_lane uByteLane (
        .iFunct3     (laneFunct3),
        .iByteOff    (laneOff),
        .iWriteData  (accWData),
        .iReadWord   (memWord),
        .oLaneMask   (laneMask),
        .oStoreData  (storeData),
        .oLoadData   (loadData),
        .oMisaligned (misaligned)
    );

    // Gating with iRST_N keeps a strobe seen while reset is held from
    // committing through the IDLE zero-wait path.
    assign memWe = doAccess & accWrite & ~misaligned & iRST_N;

    // ---------------- array (never reset) ----------------
    always_ff @(posedge iCLK) begin
        if (memWe) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (laneMask[lane]) begin
                    mem[memIdx][lane*8 +: 8] <= storeData[lane*8 +: 8];
                end
            end
        end
    end

    // ---------------- latches and outputs ----------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            addrQ     <= '0;
            wdataQ    <= 32'd0;
            funct3Q   <= 3'd0;
            writeQ    <= 1'b0;
            bothQ     <= 1'b0;
            oReadData <= 32'd0;
            oReady    <= 1'b0;
            oFault    <= 1'b0;
        end else begin
            if (latchEn) begin
                addrQ   <= iAddress[ADDR_W+1:0];
                wdataQ  <= iWriteData;
                funct3Q <= iFunct3;
                writeQ  <= iMemWrite;
                bothQ   <= iMemRead & iMemWrite;
            end
            // RESP always follows the access edge, so registering these
            // from doAccess makes them exactly the RESP-cycle pulse.
            oReady <= doAccess;
            oFault <= doAccess & (misaligned | accBoth);
            if (doAccess) begin
                if (misaligned) begin
                    oReadData <= 32'd0;
                end else if (!accWrite) begin
                    oReadData <= loadData;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder_multi.sv
`timescale 1ns/1ps
module tb_mem_responder_multi;
    import mem_responder_multi_pkg::*;

`ifdef MEM_BYTE_LANES_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] expD;
        logic        expF;
    } vec_t;

    typedef struct {
        logic [31:0] expD;
        logic        expF;
        int          idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, rst3N;
    logic        rd0, wr0, rd3, wr3;
    logic [31:0] addr0, wd0, addr3, wd3;
    logic [2:0]  f30, f33;
    logic [31:0] rdata0, rdata3;
    logic        rdy0, busy0, fault0, rdy3, busy3, fault3;

    exp_t sbq[$];
    int   nChecks = 0;
    int   nFail   = 0;

    mem_responder_multi #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .iCLK(clk), .iRST_N(rstN), .iMemRead(rd0), .iMemWrite(wr0),
        .iAddress(addr0), .iWriteData(wd0), .iFunct3(f30),
        .oReadData(rdata0), .oReady(rdy0), .oBusy(busy0), .oFault(fault0)
    );

    mem_responder_multi #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
        .iCLK(clk), .iRST_N(rst3N), .iMemRead(rd3), .iMemWrite(wr3),
        .iAddress(addr3), .iWriteData(wd3), .iFunct3(f33),
        .oReadData(rdata3), .oReady(rdy3), .oBusy(busy3), .oFault(fault3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                input logic [31:0] ed, input logic ef);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.f3 = f3; v.expD = ed; v.expF = ef;
        return v;
    endfunction

    // Scoreboard side: every oReady must match the oldest pending access.
    always @(negedge clk) begin
        exp_t e;
        if (rstN === 1'b1 && rdy0 === 1'b1) begin
            if (sbq.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_ready0: got ready=1 expected no pending access");
            end else begin
                e = sbq.pop_front();
                check($sformatf("rdata0[%0d]", e.idx), rdata0, e.expD);
                check($sformatf("fault0[%0d]", e.idx), 32'(fault0), 32'(e.expF));
            end
        end
    end

    // Called at a negedge. Strobe is held for the RESP cycle as the controller
    // does, and the next access may be driven straight after (no stall).
    task automatic run0(input vec_t v, input int idx);
        exp_t e;
        rd0 = v.rd; wr0 = v.wr; addr0 = v.addr; wd0 = v.wd; f30 = v.f3;
        e.expD = v.expD; e.expF = v.expF; e.idx = idx;
        sbq.push_back(e);
        @(negedge clk);
        check($sformatf("ready0_latency[%0d]", idx), 32'(rdy0), 32'd1);
        check($sformatf("busy0_resp[%0d]", idx), 32'(busy0), 32'd1);
        @(negedge clk);
        rd0 = 1'b0; wr0 = 1'b0;
    endtask

    // WAIT_CYCLES=3 access: strobe held two cycles with the live address/data
    // changed in the second cycle; only the latched fields may be used.
    task automatic run3(input string name, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] expD);
        rd3 = rd; wr3 = wr; addr3 = a; wd3 = wd; f33 = f3;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("%s_busy_c%0d", name, c), 32'(busy3), (c <= 4) ? 32'd1 : 32'd0);
            check($sformatf("%s_ready_c%0d", name, c), 32'(rdy3), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) check($sformatf("%s_fault", name), 32'(fault3), 32'd0);
            if (c >= 4) check($sformatf("%s_rdata_c%0d", name, c), rdata3, expD);
            if (c == 1) begin addr3 = a + 32'd4; wd3 = 32'hDEADBEEF; end
            if (c == 2) begin rd3 = 1'b0; wr3 = 1'b0; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[23];

        rstN = 1'b0; rst3N = 1'b0;
        rd0 = 0; wr0 = 0; addr0 = 0; wd0 = 0; f30 = 0;
        rd3 = 0; wr3 = 0; addr3 = 0; wd3 = 0; f33 = 0;

        vecs[0]  = mk(0, 1, 32'h10, 32'h12345678, FUNCT3_SW, 32'h0, 0);
        vecs[1]  = mk(1, 0, 32'h10, 32'h0, FUNCT3_LW, 32'h12345678, 0);
        vecs[2]  = mk(0, 1, 32'h11, 32'h000000AA, FUNCT3_SB, 32'h12345678, 0);
        vecs[3]  = mk(1, 0, 32'h11, 32'h0, FUNCT3_LB, BL ? 32'hFFFFFFAA : 32'h000000AA, 0);
        vecs[4]  = mk(1, 0, 32'h11, 32'h0, FUNCT3_LBU, 32'h000000AA, 0);
        vecs[5]  = mk(1, 0, 32'h10, 32'h0, FUNCT3_LW, BL ? 32'h1234AA78 : 32'h000000AA, 0);
        vecs[6]  = mk(1, 0, 32'h12, 32'h0, FUNCT3_LW, BL ? 32'h0 : 32'h000000AA, BL);
        vecs[7]  = mk(1, 0, 32'h10, 32'h0, FUNCT3_LW, BL ? 32'h1234AA78 : 32'h000000AA, 0);
        vecs[8]  = mk(1, 0, 32'h12, 32'h0, FUNCT3_LH, BL ? 32'h00001234 : 32'h000000AA, 0);
        vecs[9]  = mk(0, 1, 32'h14, 32'h0, FUNCT3_SW, BL ? 32'h00001234 : 32'h000000AA, 0);
        vecs[10] = mk(0, 1, 32'h16, 32'h00008001, FUNCT3_SH, BL ? 32'h00001234 : 32'h000000AA, 0);
        vecs[11] = mk(1, 0, 32'h16, 32'h0, FUNCT3_LH, BL ? 32'hFFFF8001 : 32'h00008001, 0);
        vecs[12] = mk(1, 0, 32'h16, 32'h0, FUNCT3_LHU, 32'h00008001, 0);
        vecs[13] = mk(0, 1, 32'h1010, 32'hCAFEF00D, FUNCT3_SW, 32'h00008001, 0);
        vecs[14] = mk(1, 0, 32'h10, 32'h0, FUNCT3_LW, 32'hCAFEF00D, 0);
        vecs[15] = mk(1, 1, 32'h10, 32'h55AA55AA, FUNCT3_LW, 32'hCAFEF00D, 1);
        vecs[16] = mk(1, 0, 32'h10, 32'h0, 3'b111, 32'h55AA55AA, 0);
        vecs[17] = mk(1, 0, 32'h10, 32'h0, 3'b011, 32'h55AA55AA, 0);
        vecs[18] = mk(1, 0, 32'h11, 32'h0, FUNCT3_LH, BL ? 32'h0 : 32'h55AA55AA, BL);
        vecs[19] = mk(1, 0, 32'h13, 32'h0, FUNCT3_LB, BL ? 32'h00000055 : 32'h55AA55AA, 0);
        vecs[20] = mk(1, 0, 32'h12, 32'h0, FUNCT3_LB, BL ? 32'hFFFFFFAA : 32'h55AA55AA, 0);
        vecs[21] = mk(0, 1, 32'h12, 32'h0000DEAD, FUNCT3_SW, BL ? 32'h0 : 32'h55AA55AA, BL);
        vecs[22] = mk(1, 0, 32'h10, 32'h0, FUNCT3_LW, BL ? 32'h55AA55AA : 32'h0000DEAD, 0);

        repeat (3) @(negedge clk);
        rstN = 1'b1; rst3N = 1'b1;
        @(negedge clk);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_ready0", 32'(rdy0), 32'd0);
        check("reset_busy0", 32'(busy0), 32'd0);
        check("reset_fault0", 32'(fault0), 32'd0);
        check("reset_rdata3", rdata3, 32'd0);
        check("reset_busy3", 32'(busy3), 32'd0);

        for (int i = 0; i < 23; i++) run0(vecs[i], i);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        run3("wait3_sw", 1'b0, 1'b1, 32'h20, 32'h11112222, FUNCT3_SW, 32'h0);
        run3("wait3_lw", 1'b1, 1'b0, 32'h20, 32'h0, FUNCT3_LW, 32'h11112222);

        // Reset while a store is still counting down: store must be dropped.
        rd3 = 1'b0; wr3 = 1'b1; addr3 = 32'h20; wd3 = 32'h33334444; f33 = FUNCT3_SW;
        @(negedge clk);
        @(negedge clk);
        wr3 = 1'b0;
        check("midrst_busy_before", 32'(busy3), 32'd1);
        rst3N = 1'b0;
        #1;
        check("midrst_busy", 32'(busy3), 32'd0);
        check("midrst_ready", 32'(rdy3), 32'd0);
        check("midrst_fault", 32'(fault3), 32'd0);
        check("midrst_rdata", rdata3, 32'd0);
        @(negedge clk);
        rst3N = 1'b1;
        @(negedge clk);
        run3("wait3_after_rst", 1'b1, 1'b0, 32'h20, 32'h0, FUNCT3_LW, 32'h11112222);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
